// File: rtl/ex_alu_bpred_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_bpred_if
// Brief    : Bundle of fetch-side lookup, EX-side update and ALU signals
// Revision : 1.0 - initial release
// ============================================================================
interface ex_alu_bpred_if;
    logic        br_inst_detect_pc;
    logic [31:0] pc_pc;
    logic [7:0]  pattern_ex_new;
    logic [1:0]  bht_pc;
    logic [19:0] tag_val;
    logic [31:0] pred_pc_pc;

    logic        br_inst_detect_ex;
    logic [31:0] pc_ex;
    logic [7:0]  pattern_ex;
    logic [1:0]  bht_new_ex;
    logic [31:0] pc_imm;

    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [10:0] ALUop_ex;
    logic        zero_ex;
    logic [31:0] ALU_result_ex;

    modport master (
        output br_inst_detect_pc, pc_pc, pattern_ex_new,
        output br_inst_detect_ex, pc_ex, pattern_ex, bht_new_ex, pc_imm,
        output data_a, data_b, ALUop_ex,
        input  bht_pc, tag_val, pred_pc_pc, zero_ex, ALU_result_ex
    );

    modport slave (
        input  br_inst_detect_pc, pc_pc, pattern_ex_new,
        input  br_inst_detect_ex, pc_ex, pattern_ex, bht_new_ex, pc_imm,
        input  data_a, data_b, ALUop_ex,
        output bht_pc, tag_val, pred_pc_pc, zero_ex, ALU_result_ex
    );
endinterface
`default_nettype wire

// File: rtl/ex_alu_bpred.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_bpred
// Brief    : RV32I EX-stage ALU plus gshare BHT / direct-mapped BTB storage.
//            Optional macro BPRED_BYPASS_EN forwards same-cycle writes to lookup.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_bpred (
    input  wire logic        clk,
    input  wire logic        rst,
    ex_alu_bpred_if.slave    bus
);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // Predictor storage
    // ------------------------------------------------------------------
    logic [1:0]   r_bht    [256];
    logic [255:0] r_btb_valid;
    logic [19:0]  r_btb_tag    [256];
    logic [31:0]  r_btb_target [256];

    logic [7:0] w_bht_rd_idx;
    logic [7:0] w_bht_wr_idx;
    logic [7:0] w_btb_rd_idx;
    logic [7:0] w_btb_wr_idx;
    logic       w_upd_en;

    assign w_bht_rd_idx = bus.pc_pc[9:2] ^ bus.pattern_ex_new;
    assign w_bht_wr_idx = bus.pc_ex[9:2] ^ bus.pattern_ex;
    assign w_btb_rd_idx = bus.pc_pc[9:2];
    assign w_btb_wr_idx = bus.pc_ex[9:2];
    assign w_upd_en     = bus.br_inst_detect_ex & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                r_bht[i] <= 2'b01;
            end
            r_btb_valid <= '0;
        end else if (bus.br_inst_detect_ex) begin
            r_bht[w_bht_wr_idx]       <= bus.bht_new_ex;
            r_btb_valid[w_btb_wr_idx] <= 1'b1;
        end
    end

    // Tag/target carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_upd_en) begin
            r_btb_tag[w_btb_wr_idx]    <= bus.pc_ex[31:12];
            r_btb_target[w_btb_wr_idx] <= bus.pc_imm;
        end
    end

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [1:0]  w_bht_rd;
    logic        w_btb_valid_rd;
    logic [19:0] w_btb_tag_rd;
    logic [31:0] w_btb_target_rd;

    always_comb begin
        w_bht_rd        = r_bht[w_bht_rd_idx];
        w_btb_valid_rd  = r_btb_valid[w_btb_rd_idx];
        w_btb_tag_rd    = r_btb_tag[w_btb_rd_idx];
        w_btb_target_rd = r_btb_target[w_btb_rd_idx];
`ifdef BPRED_BYPASS_EN
        if (w_upd_en && (w_bht_rd_idx == w_bht_wr_idx)) begin
            w_bht_rd = bus.bht_new_ex;
        end
        if (w_upd_en && (w_btb_rd_idx == w_btb_wr_idx)) begin
            w_btb_valid_rd  = 1'b1;
            w_btb_tag_rd    = bus.pc_ex[31:12];
            w_btb_target_rd = bus.pc_imm;
        end
`endif
    end

    always_comb begin
        bus.bht_pc     = 2'b00;
        bus.tag_val    = '0;
        bus.pred_pc_pc = '0;
        if (bus.br_inst_detect_pc) begin
            bus.bht_pc = w_bht_rd;
            if (w_btb_valid_rd) begin
                bus.tag_val    = w_btb_tag_rd;
                bus.pred_pc_pc = w_btb_target_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7_5;
    logic [4:0]  w_shamt;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_eq;
    logic        w_alt;
    logic [31:0] w_result;
    logic        w_zero;

    assign w_opcode   = bus.ALUop_ex[6:0];
    assign w_funct3   = bus.ALUop_ex[9:7];
    assign w_funct7_5 = bus.ALUop_ex[10];
    assign w_shamt    = bus.data_b[4:0];
    assign w_sum      = bus.data_a + bus.data_b;
    assign w_diff     = bus.data_a - bus.data_b;
    assign w_lt_s     = $signed(bus.data_a) < $signed(bus.data_b);
    assign w_lt_u     = bus.data_a < bus.data_b;
    assign w_eq       = bus.data_a == bus.data_b;

    // OP-IMM has no SUB; its funct7 bit only selects SRAI.
    assign w_alt = w_funct7_5 & ((w_opcode == C_OPC_OP) || (w_funct3 == 3'b101));

    always_comb begin
        w_result = w_sum;
        w_zero   = 1'b0;
        case (w_opcode)
            C_OPC_OP, C_OPC_OP_IMM: begin
                case (w_funct3)
                    3'b000:  w_result = w_alt ? w_diff : w_sum;
                    3'b001:  w_result = bus.data_a << w_shamt;
                    3'b010:  w_result = {31'd0, w_lt_s};
                    3'b011:  w_result = {31'd0, w_lt_u};
                    3'b100:  w_result = bus.data_a ^ bus.data_b;
                    3'b101:  w_result = w_alt ? 32'($signed(bus.data_a) >>> w_shamt)
                                              : (bus.data_a >> w_shamt);
                    3'b110:  w_result = bus.data_a | bus.data_b;
                    default: w_result = bus.data_a & bus.data_b;
                endcase
            end
            C_OPC_BRANCH: begin
                w_result = w_diff;
                case (w_funct3)
                    3'b000:  w_zero = w_eq;
                    3'b001:  w_zero = ~w_eq;
                    3'b100:  w_zero = w_lt_s;
                    3'b101:  w_zero = ~w_lt_s;
                    3'b110:  w_zero = w_lt_u;
                    3'b111:  w_zero = ~w_lt_u;
                    default: w_zero = 1'b0;
                endcase
            end
            C_OPC_JAL: begin
                w_zero = 1'b1;
            end
            C_OPC_JALR: begin
                w_result = {w_sum[31:1], 1'b0};
                w_zero   = 1'b1;
            end
            default: begin
                w_result = w_sum;
                w_zero   = 1'b0;
            end
        endcase
    end

    assign bus.ALU_result_ex = w_result;
    assign bus.zero_ex       = w_zero;

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.pc_pc[31:10], bus.pc_pc[1:0],
                             bus.pc_ex[11:10], bus.pc_ex[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_bpred.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_bpred
// Brief    : Directed self-checking bench for ex_alu_bpred
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_alu_bpred;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ex_alu_bpred_if bus ();

    ex_alu_bpred dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        // update asserted during reset must be ignored
        rst                   = 1'b1;
        bus.br_inst_detect_ex = 1'b1;
        bus.pc_ex             = 32'h0000_0100;
        bus.pattern_ex        = 8'h00;
        bus.bht_new_ex        = 2'b11;
        bus.pc_imm            = 32'h0000_DEAD;
        repeat (3) @(negedge clk);
        rst                   = 1'b0;
        bus.br_inst_detect_ex = 1'b0;
        bus.br_inst_detect_pc = 1'b1;
        bus.pc_pc             = 32'h0000_0100;
        bus.pattern_ex_new    = 8'h00;
        #1;
        n_cmp++;
        if (bus.bht_pc !== 2'b01) begin
            n_err++;
            $display("FAIL reset_bht: got %b expected 01", bus.bht_pc);
        end
        n_cmp++;
        if (bus.tag_val !== 20'h0) begin
            n_err++;
            $display("FAIL reset_tag: got %h expected 00000", bus.tag_val);
        end
        n_cmp++;
        if (bus.pred_pc_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_target: got %h expected 00000000", bus.pred_pc_pc);
        end
    endtask

    task automatic test_update();
        @(negedge clk);
        bus.br_inst_detect_ex = 1'b1;
        bus.pc_ex             = 32'h0000_1040;
        bus.pattern_ex        = 8'h00;
        bus.bht_new_ex        = 2'b11;
        bus.pc_imm            = 32'h0000_2000;
        @(negedge clk);
        bus.br_inst_detect_ex = 1'b0;
        bus.br_inst_detect_pc = 1'b1;
        bus.pc_pc             = 32'h0000_1040;
        bus.pattern_ex_new    = 8'h00;
        #1;
        n_cmp++;
        if (bus.bht_pc !== 2'b11) begin
            n_err++;
            $display("FAIL upd_bht: got %b expected 11", bus.bht_pc);
        end
        n_cmp++;
        if (bus.tag_val !== 20'h00001) begin
            n_err++;
            $display("FAIL upd_tag: got %h expected 00001", bus.tag_val);
        end
        n_cmp++;
        if (bus.pred_pc_pc !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL upd_target: got %h expected 00002000", bus.pred_pc_pc);
        end
        // different history -> BHT index 0x11, BTB index unchanged
        bus.pattern_ex_new = 8'h01;
        #1;
        n_cmp++;
        if (bus.bht_pc !== 2'b01) begin
            n_err++;
            $display("FAIL upd_bht_other_hist: got %b expected 01", bus.bht_pc);
        end
        n_cmp++;
        if (bus.pred_pc_pc !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL upd_target_other_hist: got %h expected 00002000", bus.pred_pc_pc);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0]  exp_bht;
        logic [19:0] exp_tag;
        logic [31:0] exp_tgt;
`ifdef BPRED_BYPASS_EN
        exp_bht = 2'b10;
        exp_tag = 20'h00005;
        exp_tgt = 32'h0000_3000;
`else
        exp_bht = 2'b11;
        exp_tag = 20'h00001;
        exp_tgt = 32'h0000_2000;
`endif
        @(negedge clk);
        bus.br_inst_detect_ex = 1'b1;
        bus.pc_ex             = 32'h0000_5040;
        bus.pattern_ex        = 8'h00;
        bus.bht_new_ex        = 2'b10;
        bus.pc_imm            = 32'h0000_3000;
        bus.br_inst_detect_pc = 1'b1;
        bus.pc_pc             = 32'h0000_5040;
        bus.pattern_ex_new    = 8'h00;
        #1;
        n_cmp++;
        if (bus.bht_pc !== exp_bht) begin
            n_err++;
            $display("FAIL same_cycle_bht: got %b expected %b", bus.bht_pc, exp_bht);
        end
        n_cmp++;
        if (bus.tag_val !== exp_tag) begin
            n_err++;
            $display("FAIL same_cycle_tag: got %h expected %h", bus.tag_val, exp_tag);
        end
        n_cmp++;
        if (bus.pred_pc_pc !== exp_tgt) begin
            n_err++;
            $display("FAIL same_cycle_target: got %h expected %h", bus.pred_pc_pc, exp_tgt);
        end
        @(negedge clk);
        bus.br_inst_detect_ex = 1'b0;
        #1;
        n_cmp++;
        if (bus.bht_pc !== 2'b10) begin
            n_err++;
            $display("FAIL after_write_bht: got %b expected 10", bus.bht_pc);
        end
        n_cmp++;
        if (bus.tag_val !== 20'h00005) begin
            n_err++;
            $display("FAIL after_write_tag: got %h expected 00005", bus.tag_val);
        end
        n_cmp++;
        if (bus.pred_pc_pc !== 32'h0000_3000) begin
            n_err++;
            $display("FAIL after_write_target: got %h expected 00003000", bus.pred_pc_pc);
        end
    endtask

    task automatic test_no_detect();
        @(negedge clk);
        bus.br_inst_detect_pc = 1'b0;
        bus.pc_pc             = 32'h0000_5040;
        bus.pattern_ex_new    = 8'h00;
        #1;
        n_cmp++;
        if ({bus.bht_pc, bus.tag_val, bus.pred_pc_pc} !== 54'h0) begin
            n_err++;
            $display("FAIL no_detect: got bht=%b tag=%h tgt=%h expected all zero",
                     bus.bht_pc, bus.tag_val, bus.pred_pc_pc);
        end
    endtask

    task automatic test_alu();
        logic [10:0] ops   [14];
        logic [31:0] as    [14];
        logic [31:0] bs    [14];
        logic [31:0] res   [14];
        logic        zs    [14];
        ops[0]  = 11'b1_000_0110011; as[0]  = 32'h5;        bs[0]  = 32'h7;        res[0]  = 32'hFFFF_FFFE; zs[0]  = 1'b0; // SUB
        ops[1]  = 11'b1_101_0110011; as[1]  = 32'h8000_0000; bs[1]  = 32'h4;       res[1]  = 32'hF800_0000; zs[1]  = 1'b0; // SRA
        ops[2]  = 11'b0_011_0110011; as[2]  = 32'h1;        bs[2]  = 32'hFFFF_FFFF; res[2]  = 32'h1;        zs[2]  = 1'b0; // SLTU
        ops[3]  = 11'b0_010_0110011; as[3]  = 32'h1;        bs[3]  = 32'hFFFF_FFFF; res[3]  = 32'h0;        zs[3]  = 1'b0; // SLT
        ops[4]  = 11'b0_001_0110011; as[4]  = 32'h1;        bs[4]  = 32'h21;       res[4]  = 32'h2;        zs[4]  = 1'b0; // SLL
        ops[5]  = 11'b0_101_0110011; as[5]  = 32'h8000_0000; bs[5]  = 32'h4;       res[5]  = 32'h0800_0000; zs[5]  = 1'b0; // SRL
        ops[6]  = 11'b1_000_0010011; as[6]  = 32'h5;        bs[6]  = 32'h7;        res[6]  = 32'hC;        zs[6]  = 1'b0; // ADDI ignores f7
        ops[7]  = 11'b0_100_1100011; as[7]  = 32'hFFFF_FFFF; bs[7]  = 32'h1;       res[7]  = 32'hFFFF_FFFE; zs[7]  = 1'b1; // BLT
        ops[8]  = 11'b0_110_1100011; as[8]  = 32'hFFFF_FFFF; bs[8]  = 32'h1;       res[8]  = 32'hFFFF_FFFE; zs[8]  = 1'b0; // BLTU
        ops[9]  = 11'b0_000_1100011; as[9]  = 32'h3;        bs[9]  = 32'h3;        res[9]  = 32'h0;        zs[9]  = 1'b1; // BEQ
        ops[10] = 11'b0_010_1100011; as[10] = 32'h3;        bs[10] = 32'h3;        res[10] = 32'h0;        zs[10] = 1'b0; // f3=010
        ops[11] = 11'b0_000_1100111; as[11] = 32'h1001;     bs[11] = 32'h2;        res[11] = 32'h1002;     zs[11] = 1'b1; // JALR
        ops[12] = 11'b0_000_1101111; as[12] = 32'h100;      bs[12] = 32'h4;        res[12] = 32'h104;      zs[12] = 1'b1; // JAL
        ops[13] = 11'b0_000_0110111; as[13] = 32'h0;        bs[13] = 32'h1234_5000; res[13] = 32'h1234_5000; zs[13] = 1'b0; // LUI
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.ALUop_ex = ops[i];
            bus.data_a   = as[i];
            bus.data_b   = bs[i];
            #1;
            n_cmp++;
            if (bus.ALU_result_ex !== res[i]) begin
                n_err++;
                $display("FAIL alu_result[%0d]: got %h expected %h", i, bus.ALU_result_ex, res[i]);
            end
            n_cmp++;
            if (bus.zero_ex !== zs[i]) begin
                n_err++;
                $display("FAIL alu_zero[%0d]: got %b expected %b", i, bus.zero_ex, zs[i]);
            end
        end
    endtask

    initial begin
        n_cmp                 = 0;
        n_err                 = 0;
        rst                   = 1'b1;
        bus.br_inst_detect_pc = 1'b0;
        bus.pc_pc             = '0;
        bus.pattern_ex_new    = '0;
        bus.br_inst_detect_ex = 1'b0;
        bus.pc_ex             = '0;
        bus.pattern_ex        = '0;
        bus.bht_new_ex        = '0;
        bus.pc_imm            = '0;
        bus.data_a            = '0;
        bus.data_b            = '0;
        bus.ALUop_ex          = '0;
        test_reset();
        test_update();
        test_same_cycle();
        test_no_detect();
        test_alu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_alu_bpred.md
# ex_alu_bpred

Execute-stage arithmetic unit combined with the fetch-stage branch predictor storage of the RV32I pipeline. The ALU evaluates RV32I integer operations and branch conditions for the instruction in EX. A gshare-indexed 2-bit branch history table (BHT) and a direct-mapped branch target buffer (BTB) are read combinationally for the PC in fetch and written from EX-stage branch resolution. Next-PC selection, the 2-bit FSM and history shifting live outside this block.

## Interface
Parameters:
- none (sizes fixed: 256 BHT entries, 256 BTB entries, 8-bit history)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- br_inst_detect_pc  in  1  fetch instruction is a branch/jump
- pc_pc  in  32  fetch PC
- pattern_ex_new  in  8  current global history, used for lookup
- bht_pc  out  2  predicted counter for pc_pc
- tag_val  out  20  stored tag for pc_pc's BTB entry
- pred_pc_pc  out  32  predicted target for pc_pc
- br_inst_detect_ex  in  1  EX instruction is a branch/jump (update enable)
- pc_ex  in  32  EX PC
- pattern_ex  in  8  history captured at prediction time for the EX instruction
- bht_new_ex  in  2  new counter value to store
- pc_imm  in  32  resolved target to store
- data_a, data_b  in  32  ALU operands
- ALUop_ex  in  11  {funct7[5], funct3[2:0], opcode[6:0]}
- zero_ex  out  1  branch/jump condition true
- ALU_result_ex  out  32  ALU result

## Operation
- BHT lookup index = pc_pc[9:2] XOR pattern_ex_new; update index = pc_ex[9:2] XOR pattern_ex.
- BTB lookup index = pc_pc[9:2]; update index = pc_ex[9:2]; entry = {valid, tag pc[31:12], target[31:0]}.
- Lookup (combinational): if br_inst_detect_pc=0 then bht_pc=2'b00, tag_val=0, pred_pc_pc=0. Otherwise bht_pc = entry counter; if the BTB entry is valid, tag_val/pred_pc_pc = stored tag/target, else both 0.
- Update (rising edge, br_inst_detect_ex=1, rst=0): BHT[update idx] <= bht_new_ex; BTB[update idx] <= {1, pc_ex[31:12], pc_imm}. br_inst_detect_ex=0: no state change.
- ALU, opcode 0110011 (OP): funct3 000 ADD/SUB (funct7[5]=1 SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7[5]), 110 OR, 111 AND. Shift amount = data_b[4:0].
- Opcode 0010011 (OP-IMM): same but funct3 000 is always ADD; funct7[5] honoured only for funct3 101.
- Opcode 1100011: result = data_a - data_b; zero_ex = BEQ eq, BNE ne, BLT signed lt, BGE signed ge, BLTU unsigned lt, BGEU unsigned ge; funct3 010/011 give zero_ex=0.
- Opcodes 1101111 (JAL), 1100111 (JALR): result = data_a + data_b, JALR with bit 0 cleared; zero_ex=1.
- All other opcodes (load, store, AUIPC, LUI, unknown): result = data_a + data_b, zero_ex=0. For non-branch/non-jump opcodes zero_ex=0 always.
- Arithmetic modulo 2^32; no overflow flag.

## Timing
- ALU and lookup paths purely combinational, zero latency.
- Update visible to a lookup on the cycle after the write edge.
- Reset: all BHT counters <= 2'b01, all BTB valid <= 0 (tags/targets don't-care). Reset dominates a simultaneous update. Following cycle: any lookup with br_inst_detect_pc=1 gives bht_pc=01, tag_val=0, pred_pc_pc=0.
- Same-cycle lookup and update of the same index: lookup returns pre-write contents (see Configuration).

## Configuration
- BPRED_BYPASS_EN defined: when update is active and the lookup index equals the update index (BHT and BTB checked independently), lookup outputs return the data being written this cycle.
- Undefined: lookup always returns stored (old) contents.

## Test plan
- Reset, then br_inst_detect_pc=1, pc_pc=0x100, pattern 0 -> bht_pc=01, tag_val=0, pred_pc_pc=0.
- Update pc_ex=0x0000_1040, pattern_ex=0, bht_new_ex=11, pc_imm=0x2000; next cycle lookup pc_pc=0x1040, pattern 0 -> bht_pc=11, tag_val=0x00001, pred_pc_pc=0x2000; with pattern_ex_new=0x01 -> bht_pc=01 (different BHT index).
- Same-cycle update/lookup of index 0x10 -> old value without BPRED_BYPASS_EN, new value with it.
- ALUop SUB (funct7[5]=1, 000, 0110011), a=5, b=7 -> 0xFFFFFFFE; SRA a=0x80000000, b=4 -> 0xF8000000; SLTU a=1, b=0xFFFFFFFF -> 1.
- BLT a=0xFFFFFFFF, b=1 -> zero_ex=1; BLTU same operands -> zero_ex=0; BEQ a=b=3 -> zero_ex=1.
- JALR a=0x1001, b=2 -> result 0x1002, zero_ex=1; br_inst_detect_pc=0 -> all lookup outputs 0.
